axis_uart_rx_os: RTL and testbench

- Next-generation AXI-Stream UART receiver: 16x oversampling, 3-sample majority vote and a fractional baud divider.
- Adds runtime-configurable frame format, framing-error and break detection, and an output FIFO with overflow reporting.
- Sits between the board RX pin and the packet/command logic. Drop-in receive side of the UART subsystem.

---
 rtl/axis_uart_rx_os.sv | 205 ++++++++++++++++++++
 tb/tb_axis_uart_rx_os.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_uart_rx_os.sv
// AXI-Stream UART receiver: 16x oversampling with a 3-sample majority vote and a fractional baud divider.
// Supports a runtime frame format, framing-error/break flags, and an output FIFO that reports overflow.
module axis_uart_rx_os #(
    parameter logic [19:0] BAUD_DIV       = 20'd1085,
    parameter int          PARITY         = 0,
    parameter int          BYTE_SIZE      = 8,
    parameter int          STOP_BITS      = 0,
    parameter int          FIFO_DEPTH     = 16,
    parameter int          DYNAMIC_CONFIG = 0
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [27:0] s_axis_config_tdata,
    input  logic        s_axis_config_tvalid,
    output logic        s_axis_config_tready,
    output logic [15:0] m_axis_tdata,
    output logic [2:0]  m_axis_tuser,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    input  logic        rxd,
    output logic        overflow
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;

    state_t      state, state_next;
    logic [19:0] cfg_div;
    logic [2:0]  cfg_parity;
    logic [4:0]  cfg_size;
    logic        cfg_stop;
    logic        rxd_meta, rxd_sync;
    logic [20:0] acc, acc_inc, div_eff;
    logic        tick, mid, bit_end;
    logic [3:0]  tick_cnt, brk_cnt;
    logic        samp0, samp1, maj;
    logic [4:0]  bit_idx;
    logic [15:0] shreg;
    logic        perr, ferr, par_bit, stop_idx;
    logic        has_par, exp_par, last_stop, ferr_fin, brk_det, push;
    logic [18:0] push_word;

    assign s_axis_config_tready = (DYNAMIC_CONFIG != 0) && (state == IDLE);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cfg_div    <= BAUD_DIV;
            cfg_parity <= 3'(PARITY);
            cfg_size   <= 5'(BYTE_SIZE);
            cfg_stop   <= (STOP_BITS != 0);
        end else if (s_axis_config_tvalid && s_axis_config_tready) begin
            cfg_div    <= s_axis_config_tdata[19:0];
            cfg_parity <= s_axis_config_tdata[22:20];
            cfg_size   <= (s_axis_config_tdata[26:23] == 4'd0) ? 5'd16 : {1'b0, s_axis_config_tdata[26:23]};
            cfg_stop   <= s_axis_config_tdata[27];
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
        end
    end

    // Divisors below 2 clocks per tick are clamped so the bit timing stays meaningful.
    assign div_eff  = (cfg_div < 20'd32) ? 21'd32 : {1'b0, cfg_div};
    assign acc_inc  = acc + 21'd16;
    assign tick     = (acc_inc >= div_eff);
    assign mid      = tick && (tick_cnt == 4'd9);
    assign bit_end  = tick && (tick_cnt == 4'd15);
    assign maj      = (samp0 & samp1) | (samp0 & rxd_sync) | (samp1 & rxd_sync);

    assign has_par   = (cfg_parity >= 3'd1) && (cfg_parity <= 3'd4);
    assign last_stop = (stop_idx == cfg_stop);
    assign ferr_fin  = ferr | ~maj;
    assign brk_det   = (shreg == 16'd0) && !par_bit && ferr_fin;
    assign push      = (state == STOP) && mid && last_stop;
    assign push_word = {brk_det, ferr_fin, perr, shreg};

    always_comb begin
        exp_par = 1'b0;
        case (cfg_parity)
            3'd1:    exp_par = ^shreg;
            3'd2:    exp_par = ~^shreg;
            3'd3:    exp_par = 1'b1;
            default: exp_par = 1'b0;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (!rxd_sync) state_next = START;
            START: begin
                if (mid && maj)   state_next = IDLE;
                else if (bit_end) state_next = DATA;
            end
            DATA:  if (bit_end && (bit_idx == cfg_size - 5'd1)) state_next = has_par ? PAR : STOP;
            PAR:   if (bit_end) state_next = STOP;
            STOP:  if (mid && last_stop) state_next = brk_det ? BRK : IDLE;
            BRK:   if (tick && rxd_sync && (brk_cnt == 4'd15)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Frame datapath: every per-frame register is cleared while idle, so a new frame starts clean.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            acc      <= '0;
            tick_cnt <= '0;
            samp0    <= 1'b1;
            samp1    <= 1'b1;
            bit_idx  <= '0;
            shreg    <= '0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            par_bit  <= 1'b0;
            stop_idx <= 1'b0;
            brk_cnt  <= '0;
        end else begin
            if (state == IDLE && !rxd_sync) acc <= '0;
            else                            acc <= tick ? (acc_inc - div_eff) : acc_inc;
            if (state == IDLE) begin
                tick_cnt <= '0;
                bit_idx  <= '0;
                shreg    <= '0;
                perr     <= 1'b0;
                ferr     <= 1'b0;
                par_bit  <= 1'b0;
                stop_idx <= 1'b0;
                brk_cnt  <= '0;
            end else if (tick) begin
                tick_cnt <= tick_cnt + 4'd1;
                if (tick_cnt == 4'd7) samp0 <= rxd_sync;
                if (tick_cnt == 4'd8) samp1 <= rxd_sync;
                case (state)
                    DATA: begin
                        if (tick_cnt == 4'd9)  shreg[bit_idx[3:0]] <= maj;
                        if (tick_cnt == 4'd15) bit_idx <= bit_idx + 5'd1;
                    end
                    PAR: if (tick_cnt == 4'd9) begin
                        par_bit <= maj;
                        perr    <= (maj != exp_par);
                    end
                    STOP: begin
                        if (tick_cnt == 4'd9)  ferr <= ferr_fin;
                        if (tick_cnt == 4'd15) stop_idx <= 1'b1;
                    end
                    BRK: brk_cnt <= rxd_sync ? (brk_cnt + 4'd1) : 4'd0;
                    default: ;
                endcase
            end
        end
    end

    logic [18:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_next;
    logic [CW-1:0] count, count_next;
    logic          full, rd_en, wr_en;

    assign full        = (count == CW'(FIFO_DEPTH));
    assign rd_en       = m_axis_tvalid && m_axis_tready;
    assign wr_en       = push && (!full || rd_en);
    assign count_next  = count + CW'(wr_en) - CW'(rd_en);
    assign rd_ptr_next = rd_ptr + AW'(rd_en);

    always_ff @(posedge aclk) begin
        if (wr_en) mem[wr_ptr] <= push_word;
    end

    // The output register always mirrors the FIFO head; a word written into an empty FIFO bypasses memory.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= '0;
            overflow      <= 1'b0;
        end else begin
            wr_ptr        <= wr_ptr + AW'(wr_en);
            rd_ptr        <= rd_ptr_next;
            count         <= count_next;
            m_axis_tvalid <= (count_next != '0);
            overflow      <= push && full && !rd_en;
            if (wr_en && (count == CW'(rd_en)))
                {m_axis_tuser, m_axis_tdata} <= push_word;
            else if (count_next != '0)
                {m_axis_tuser, m_axis_tdata} <= mem[rd_ptr_next];
        end
    end

endmodule

// File: tb/tb_axis_uart_rx_os.sv
// Directed bench for axis_uart_rx_os at 4 clocks per oversample tick (64 clocks per bit).
// Captures output words and overflow pulses in a monitor and compares them against hand-computed values.
module tb_axis_uart_rx_os;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [27:0] s_axis_config_tdata = '0;
    logic        s_axis_config_tvalid = 1'b0;
    logic        s_axis_config_tready;
    logic [15:0] m_axis_tdata;
    logic [2:0]  m_axis_tuser;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        rxd = 1'b1;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rise_cyc = -1;
    int ovf_count = 0;
    int word_count = 0;
    int wc = 0;
    logic tvalid_d = 1'b0;
    logic [15:0] got_data [$];
    logic [2:0]  got_user [$];
    logic [7:0]  vals [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    axis_uart_rx_os #(
        .BAUD_DIV(20'd64),
        .FIFO_DEPTH(4),
        .DYNAMIC_CONFIG(1)
    ) dut (
        .aclk(aclk),
        .areset(areset),
        .s_axis_config_tdata(s_axis_config_tdata),
        .s_axis_config_tvalid(s_axis_config_tvalid),
        .s_axis_config_tready(s_axis_config_tready),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .rxd(rxd),
        .overflow(overflow)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    // Outputs are observed on the falling edge, half a cycle away from the DUT's active edge.
    always @(negedge aclk) begin
        if (m_axis_tvalid && !tvalid_d) rise_cyc = cyc;
        tvalid_d = m_axis_tvalid;
        if (overflow) ovf_count++;
        if (m_axis_tvalid && m_axis_tready) begin
            got_data.push_back(m_axis_tdata);
            got_user.push_back(m_axis_tuser);
            word_count++;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        wait_clk(64);
    endtask

    // nstop stop bits are sent; all but the last are 1, the last takes last_stop. par < 0 means no parity bit.
    task automatic send_frame(input logic [15:0] data, input int nbits, input int par,
                              input int nstop, input logic last_stop);
        wait_clk(1);
        start_cyc = cyc;
        rise_cyc  = -1;
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) send_bit(data[i]);
        if (par >= 0) send_bit(par[0]);
        for (int i = 0; i < nstop; i++) send_bit((i == nstop - 1) ? last_stop : 1'b1);
        rxd = 1'b1;
    endtask

    task automatic apply_stimulus(input logic [19:0] div, input logic [2:0] par,
                                  input logic [3:0] size, input logic stop);
        int n = 0;
        while (!s_axis_config_tready && n < 2000) begin
            wait_clk(1);
            n++;
        end
        check_output("cfg_ready", {31'd0, s_axis_config_tready}, 32'd1);
        s_axis_config_tdata  = {stop, size, par, div};
        s_axis_config_tvalid = 1'b1;
        wait_clk(1);
        s_axis_config_tvalid = 1'b0;
    endtask

    task automatic expect_word(input string tag, input logic [15:0] data, input logic [2:0] user);
        int n = 0;
        while (got_data.size() == 0 && n < 3000) begin
            wait_clk(1);
            n++;
        end
        if (got_data.size() == 0) begin
            check_output({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check_output({tag, "_data"}, {16'd0, got_data.pop_front()}, {16'd0, data});
            check_output({tag, "_user"}, {29'd0, got_user.pop_front()}, {29'd0, user});
        end
    endtask

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        wait_clk(3);
        check_output("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check_output("rst_tdata", {16'd0, m_axis_tdata}, 32'd0);
        check_output("rst_tuser", {29'd0, m_axis_tuser}, 32'd0);
        check_output("rst_overflow", {31'd0, overflow}, 32'd0);
        areset = 1'b0;
        wait_clk(2);
        check_output("rst_cfg_ready", {31'd0, s_axis_config_tready}, 32'd1);

        // 8N1 0x55: tvalid rises 619 clocks after rxd falls (2 sync + 1 detect + 154 ticks of 4 clocks).
        m_axis_tready = 1'b1;
        apply_stimulus(20'd64, 3'd0, 4'd8, 1'b0);
        wait_clk(20);
        send_frame(16'h0055, 8, -1, 1, 1'b1);
        wait_clk(64);
        expect_word("t1", 16'h0055, 3'b000);
        check_output("t1_latency", rise_cyc - start_cyc, 32'd619);

        // 8E1 0xA3 has four ones, so the even parity bit must be 0.
        apply_stimulus(20'd64, 3'd1, 4'd8, 1'b0);
        send_frame(16'h00A3, 8, 1, 1, 1'b1);
        expect_word("t2_badpar", 16'h00A3, 3'b001);
        send_frame(16'h00A3, 8, 0, 1, 1'b1);
        expect_word("t2_goodpar", 16'h00A3, 3'b000);

        apply_stimulus(20'd64, 3'd0, 4'd9, 1'b1);
        send_frame(16'h01FF, 9, -1, 2, 1'b0);
        wait_clk(128);
        expect_word("t3_ferr", 16'h01FF, 3'b010);

        // A long break yields exactly one flagged word, then normal reception resumes.
        apply_stimulus(20'd64, 3'd0, 4'd8, 1'b0);
        wc = word_count;
        wait_clk(1);
        rxd = 1'b0;
        wait_clk(12 * 64);
        rxd = 1'b1;
        wait_clk(300);
        expect_word("t4_brk", 16'h0000, 3'b110);
        send_frame(16'h0041, 8, -1, 1, 1'b1);
        wait_clk(64);
        expect_word("t4_next", 16'h0041, 3'b000);
        check_output("t4_words", word_count - wc, 32'd2);

        wc = word_count;
        wait_clk(1);
        rxd = 1'b0;
        wait_clk(12);
        rxd = 1'b1;
        check_output("t5_busy_ready", {31'd0, s_axis_config_tready}, 32'd0);
        wait_clk(100);
        check_output("t5_idle_ready", {31'd0, s_axis_config_tready}, 32'd1);
        check_output("t5_words", word_count - wc, 32'd0);

        // Six frames into a 4-deep FIFO with no consumer: the last two are dropped.
        m_axis_tready = 1'b0;
        ovf_count = 0;
        for (int i = 0; i < 6; i++) send_frame({8'd0, vals[i]}, 8, -1, 1, 1'b1);
        wait_clk(64);
        check_output("t6_overflows", ovf_count, 32'd2);
        check_output("t6_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
        check_output("t6_head_stable", {16'd0, m_axis_tdata}, 32'h11);
        m_axis_tready = 1'b1;
        for (int i = 0; i < 4; i++) expect_word("t6_drain", {8'd0, vals[i]}, 3'b000);
        wait_clk(10);
        check_output("t6_extra", got_data.size(), 32'd0);

        // Reset mid-frame must clear a held word at once and restore the parameter format.
        m_axis_tready = 1'b0;
        send_frame(16'h005A, 8, -1, 1, 1'b1);
        wait_clk(64);
        check_output("t7_held", {31'd0, m_axis_tvalid}, 32'd1);
        wait_clk(1);
        rxd = 1'b0;
        wait_clk(64);
        wait_clk(64);
        rxd = 1'b1;
        wait_clk(64);
        areset = 1'b1;
        #1;
        check_output("t7_rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check_output("t7_rst_tdata", {16'd0, m_axis_tdata}, 32'd0);
        wait_clk(3);
        areset = 1'b0;
        wait_clk(100);
        m_axis_tready = 1'b1;
        send_frame(16'h00C3, 8, -1, 1, 1'b1);
        wait_clk(64);
        expect_word("t7_after", 16'h00C3, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
